// File: rtl/pwm_sched_pkg.sv
// pwm_sched_pkg: shared state encoding and default sizing for the PWM scheduler.
// The GAP encoding is reserved here even when PWM_SCHED_GAP_EN is undefined,
// so waveforms decode the same way in every build.
package pwm_sched_pkg;

    localparam int NCH_DEF        = 4;
    localparam int PW_DEF         = 12;
    localparam int GAP_CYCLES_DEF = 4;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_PULSE = 2'd1,
        ST_DONE  = 2'd2,
        ST_GAP   = 2'd3
    } state_e;

endpackage

// File: rtl/pwm_pulse_core.sv
// pwm_pulse_core: down-counting pulse timer driving the registered PWM output.
// A start with a non-zero width raises pwm for exactly 'width' cycles.
// 'done' flags the last high cycle so the scheduler can leave PULSE on the
// same edge that drops pwm. A zero width is ignored and pwm stays low.
// The width is captured at start, so later changes on 'width' have no effect.
module pwm_pulse_core #(
    parameter int PW = 12
) (
    input  logic          clk,
    input  logic          rst,
    input  logic          start,
    input  logic [PW-1:0] width,
    output logic          pwm,
    output logic          busy,
    output logic          done
);

    logic          pwm_q, pwm_d;
    logic [PW-1:0] cnt_q, cnt_d;

    // Next-state for the counter: load on start, count down while high.
    // The terminal compare at 1 means the count never passes zero and wraps.
    always_comb begin
        pwm_d = pwm_q;
        cnt_d = cnt_q;
        if (start && (width != '0)) begin
            pwm_d = 1'b1;
            cnt_d = width;
        end else if (pwm_q) begin
            if (cnt_q == PW'(1)) begin
                pwm_d = 1'b0;
                cnt_d = '0;
            end else begin
                cnt_d = cnt_q - PW'(1);
            end
        end
    end

    // Counter and PWM registers with synchronous reset.
    always_ff @(posedge clk) begin
        if (rst) begin
            pwm_q <= 1'b0;
            cnt_q <= '0;
        end else begin
            pwm_q <= pwm_d;
            cnt_q <= cnt_d;
        end
    end

    assign pwm  = pwm_q;
    assign busy = pwm_q;
    assign done = pwm_q && (cnt_q == PW'(1));

endmodule

// File: rtl/pwm_sched.sv
// pwm_sched: round-robin scheduler that serves one channel's PWM pulse at a time
// on a shared output.
// Optional build macro PWM_SCHED_GAP_EN inserts GAP_CYCLES guard cycles
// after every pulse.
//
//  state    | meaning
//  ---------+-----------------------------------------------------------
//  ST_IDLE  | sample requests, grant the next channel round-robin
//  ST_PULSE | pulse core drives o_pwm high for the latched width
//  ST_DONE  | one cycle, o_done[o_ch] high, o_pwm low
//  ST_GAP   | guard interval, o_pwm low, o_busy high (PWM_SCHED_GAP_EN only)
module pwm_sched
    import pwm_sched_pkg::*;
#(
    parameter int NCH        = NCH_DEF,
    parameter int PW         = PW_DEF,
    parameter int GAP_CYCLES = GAP_CYCLES_DEF
) (
    input  logic                   clk,
    input  logic                   rst,
    input  logic [NCH-1:0]         i_req,
    input  logic [NCH*PW-1:0]      i_width,
    output logic                   o_pwm,
    output logic [NCH-1:0]         o_gnt,
    output logic [NCH-1:0]         o_done,
    output logic [$clog2(NCH)-1:0] o_ch,
    output logic                   o_busy
);

    localparam int CW = $clog2(NCH);

    state_e         state_q, state_d;
    logic [CW-1:0]  last_q, last_d;
    logic [CW-1:0]  ch_q, ch_d;
    logic [NCH-1:0] gnt_q, gnt_d;
    logic [NCH-1:0] done_vec;

    logic           rr_hit;
    logic [CW-1:0]  rr_idx;
    logic [PW-1:0]  sel_w;

    logic           core_start;
    logic           core_busy;
    logic           core_done;

`ifdef PWM_SCHED_GAP_EN
    localparam int GW = (GAP_CYCLES < 2) ? 1 : $clog2(GAP_CYCLES + 1);
    logic [GW-1:0] gap_cnt_q, gap_cnt_d;
`else
    // GAP_CYCLES only matters when the guard interval is built.
    if (GAP_CYCLES < 0) begin : g_gap_cycles_negative
    end
`endif

    // Round-robin search starting one past the last granted channel.
    always_comb begin
        int            cand;
        logic [CW-1:0] cidx;
        rr_hit = 1'b0;
        rr_idx = '0;
        cand   = 0;
        cidx   = '0;
        for (int k = 1; k <= NCH; k++) begin
            cand = (int'(last_q) + k) % NCH;
            cidx = CW'(cand);
            if (!rr_hit && i_req[cidx]) begin
                rr_hit = 1'b1;
                rr_idx = cidx;
            end
        end
    end

    assign sel_w = i_width[rr_idx*PW +: PW];

    // FSM next-state, grant and done decode.
    always_comb begin
        state_d    = state_q;
        last_d     = last_q;
        ch_d       = ch_q;
        gnt_d      = '0;
        done_vec   = '0;
        core_start = 1'b0;
`ifdef PWM_SCHED_GAP_EN
        gap_cnt_d  = gap_cnt_q;
`endif
        case (state_q)
            ST_IDLE: begin
                if (rr_hit) begin
                    gnt_d      = {{(NCH-1){1'b0}}, 1'b1} << rr_idx;
                    ch_d       = rr_idx;
                    last_d     = rr_idx;
                    core_start = 1'b1;
                    state_d    = (sel_w == '0) ? ST_DONE : ST_PULSE;
                end
            end
            ST_PULSE: begin
                if (core_done) begin
                    state_d = ST_DONE;
                end
            end
            ST_DONE: begin
                done_vec = {{(NCH-1){1'b0}}, 1'b1} << ch_q;
`ifdef PWM_SCHED_GAP_EN
                if (GAP_CYCLES > 0) begin
                    state_d   = ST_GAP;
                    gap_cnt_d = GW'(GAP_CYCLES);
                end else begin
                    state_d = ST_IDLE;
                end
`else
                state_d = ST_IDLE;
`endif
            end
`ifdef PWM_SCHED_GAP_EN
            ST_GAP: begin
                if (gap_cnt_q <= GW'(1)) begin
                    state_d   = ST_IDLE;
                    gap_cnt_d = '0;
                end else begin
                    gap_cnt_d = gap_cnt_q - GW'(1);
                end
            end
`endif
            default: begin
                state_d = ST_IDLE;
            end
        endcase
    end

    // State, channel bookkeeping and grant registers.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= ST_IDLE;
            last_q  <= CW'(NCH - 1);
            ch_q    <= '0;
            gnt_q   <= '0;
        end else begin
            state_q <= state_d;
            last_q  <= last_d;
            ch_q    <= ch_d;
            gnt_q   <= gnt_d;
        end
    end

`ifdef PWM_SCHED_GAP_EN
    // Guard-interval down-counter.
    always_ff @(posedge clk) begin
        if (rst) begin
            gap_cnt_q <= '0;
        end else begin
            gap_cnt_q <= gap_cnt_d;
        end
    end
`endif

    pwm_pulse_core #(
        .PW (PW)
    ) u_core (
        .clk   (clk),
        .rst   (rst),
        .start (core_start),
        .width (sel_w),
        .pwm   (o_pwm),
        .busy  (core_busy),
        .done  (core_done)
    );

    assign o_gnt  = gnt_q;
    assign o_done = done_vec;
    assign o_ch   = ch_q;
    assign o_busy = (state_q != ST_IDLE) || core_busy;

endmodule

// File: tb/tb_pwm_sched.sv
// tb_pwm_sched: directed checks of the PWM scheduler with hand-computed
// expected values. It covers reset, single pulse, round robin, zero width,
// width latch, reset mid-pulse, maximum width and the optional guard gap.
module tb_pwm_sched;

    localparam int NCH = 4;
    localparam int PW  = 12;
`ifdef PWM_SCHED_GAP_EN
    localparam int GAPC = 4;
`else
    localparam int GAPC = 0;
`endif
    localparam logic GAP_BUSY = (GAPC > 0);

    logic              clk = 1'b0;
    logic              rst;
    logic [NCH-1:0]    i_req;
    logic [NCH*PW-1:0] i_width;
    logic              o_pwm;
    logic [NCH-1:0]    o_gnt;
    logic [NCH-1:0]    o_done;
    logic [1:0]        o_ch;
    logic              o_busy;

    int errors = 0;
    int checks = 0;

    pwm_sched #(
        .NCH        (NCH),
        .PW         (PW),
        .GAP_CYCLES (4)
    ) dut (
        .clk     (clk),
        .rst     (rst),
        .i_req   (i_req),
        .i_width (i_width),
        .o_pwm   (o_pwm),
        .o_gnt   (o_gnt),
        .o_done  (o_done),
        .o_ch    (o_ch),
        .o_busy  (o_busy)
    );

    always #5 clk = ~clk;

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic set_w(input int ch, input int val);
        i_width[ch*PW +: PW] = PW'(val);
    endtask

    task automatic wait_idle(input int budget);
        int n;
        n = 0;
        while (o_busy && n < budget) begin
            step();
            n++;
        end
        chk("idle_reached", 32'(o_busy), 32'd0);
    endtask

    // Steps until the next grant; hi counts pwm-high cycles from the current
    // grant cycle up to (not including) the next grant.
    task automatic wait_gnt(input int budget, output int n, output int hi);
        n  = 0;
        hi = int'(o_pwm);
        while (n < budget) begin
            step();
            n++;
            if (o_gnt != '0) break;
            hi += int'(o_pwm);
        end
    endtask

    // Steps until o_done; hi counts pwm-high cycles including the current one.
    task automatic count_pulse(input int budget, output int hi);
        int n;
        n  = 0;
        hi = int'(o_pwm);
        while (o_done == '0 && n < budget) begin
            step();
            n++;
            hi += int'(o_pwm);
        end
    endtask

    initial begin
        #1_000_000;
        $display("FAIL watchdog timeout");
        $fatal(1, "watchdog");
    end

    initial begin
        int n;
        int hi;
        logic [NCH-1:0] rr_exp [4];
        rr_exp[0] = 4'b0010;
        rr_exp[1] = 4'b0100;
        rr_exp[2] = 4'b1000;
        rr_exp[3] = 4'b0001;

        rst     = 1'b1;
        i_req   = '0;
        i_width = '0;
        step();
        step();
        chk("rst_pwm",  32'(o_pwm),  32'd0);
        chk("rst_gnt",  32'(o_gnt),  32'd0);
        chk("rst_done", 32'(o_done), 32'd0);
        chk("rst_busy", 32'(o_busy), 32'd0);
        chk("rst_ch",   32'(o_ch),   32'd0);
        rst = 1'b0;
        step();
        step();
        chk("idle_noreq_busy", 32'(o_busy), 32'd0);
        chk("idle_noreq_pwm",  32'(o_pwm),  32'd0);
        chk("idle_noreq_gnt",  32'(o_gnt),  32'd0);

        // Single request, width 5.
        set_w(0, 5);
        i_req = 4'b0001;
        step();
        chk("s1_gnt",  32'(o_gnt),  32'h1);
        chk("s1_pwm0", 32'(o_pwm),  32'd1);
        chk("s1_busy", 32'(o_busy), 32'd1);
        chk("s1_ch",   32'(o_ch),   32'd0);
        for (int i = 0; i < 4; i++) begin
            step();
            chk("s1_pwm_hi",  32'(o_pwm),  32'd1);
            chk("s1_gnt_off", 32'(o_gnt),  32'd0);
            chk("s1_done_lo", 32'(o_done), 32'd0);
        end
        step();
        chk("s1_pwm_end", 32'(o_pwm),  32'd0);
        chk("s1_done",    32'(o_done), 32'h1);
        i_req = '0;
        step();
        chk("s1_done_once", 32'(o_done), 32'd0);
        chk("s1_after_busy", 32'(o_busy), 32'(GAP_BUSY));
        wait_idle(20);

        // Round robin from reset, all widths 2.
        rst = 1'b1;
        step();
        rst = 1'b0;
        for (int c = 0; c < NCH; c++) set_w(c, 2);
        i_req = 4'b1111;
        step();
        chk("rr_first_gnt", 32'(o_gnt), 32'h1);
        for (int g = 0; g < 4; g++) begin
            wait_gnt(20, n, hi);
            chk("rr_spacing", 32'(n),     32'(4 + GAPC));
            chk("rr_gnt",     32'(o_gnt), 32'(rr_exp[g]));
            chk("rr_hi",      32'(hi),    32'd2);
        end
        i_req = '0;
        wait_idle(20);

        // Zero width on channel 2: grant and done together, pwm never high.
        set_w(2, 0);
        i_req = 4'b0100;
        step();
        chk("zw_gnt",  32'(o_gnt),  32'h4);
        chk("zw_done", 32'(o_done), 32'h4);
        chk("zw_pwm",  32'(o_pwm),  32'd0);
        chk("zw_ch",   32'(o_ch),   32'd2);
        i_req = '0;
        step();
        chk("zw_pwm_after",  32'(o_pwm),  32'd0);
        chk("zw_done_after", 32'(o_done), 32'd0);
        chk("zw_busy_after", 32'(o_busy), 32'(GAP_BUSY));
        wait_idle(20);

        // Width latch: width1=8 at grant, changed to 2 mid-pulse.
        set_w(1, 8);
        i_req = 4'b0010;
        step();
        chk("wl_gnt", 32'(o_gnt), 32'h2);
        set_w(1, 2);
        step();
        count_pulse(30, hi);
        chk("wl_hi",   32'(hi + 1), 32'd8);
        chk("wl_done", 32'(o_done), 32'h2);
        i_req = '0;
        wait_idle(20);

        // Reset in cycle 3 of a 10-cycle pulse on channel 3.
        set_w(3, 10);
        i_req = 4'b1000;
        step();
        chk("rm_gnt", 32'(o_gnt), 32'h8);
        step();
        step();
        chk("rm_pwm_c3", 32'(o_pwm), 32'd1);
        rst = 1'b1;
        step();
        chk("rm_pwm",  32'(o_pwm),  32'd0);
        chk("rm_done", 32'(o_done), 32'd0);
        chk("rm_busy", 32'(o_busy), 32'd0);
        rst   = 1'b0;
        i_req = 4'b1111;
        step();
        chk("rm_next_gnt", 32'(o_gnt), 32'h1);
        i_req = '0;
        wait_idle(20);

        // Maximum width: 4095 high cycles, no wrap.
        set_w(0, 4095);
        i_req = 4'b0001;
        wait_gnt(4, n, hi);
        chk("mx_gnt", 32'(o_gnt), 32'h1);
        count_pulse(5000, hi);
        chk("mx_hi",   32'(hi),     32'd4095);
        chk("mx_done", 32'(o_done), 32'h1);
        i_req = '0;
        wait_idle(20);

`ifdef PWM_SCHED_GAP_EN
        // Guard gap between two width-1 pulses.
        rst = 1'b1;
        step();
        rst = 1'b0;
        set_w(0, 1);
        set_w(1, 1);
        i_req = 4'b0011;
        step();
        chk("gp_gnt0", 32'(o_gnt), 32'h1);
        chk("gp_pwm0", 32'(o_pwm), 32'd1);
        step();
        chk("gp_done0", 32'(o_done), 32'h1);
        chk("gp_pwm_d", 32'(o_pwm),  32'd0);
        for (int i = 0; i < 4; i++) begin
            step();
            chk("gp_gap_pwm",  32'(o_pwm),  32'd0);
            chk("gp_gap_busy", 32'(o_busy), 32'd1);
            chk("gp_gap_gnt",  32'(o_gnt),  32'd0);
        end
        step();
        chk("gp_idle", 32'(o_busy), 32'd0);
        step();
        chk("gp_gnt1", 32'(o_gnt), 32'h2);
        i_req = '0;
        wait_idle(20);
`endif

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
